// File: rtl/irq_encoder_8to3.sv
// -----------------------------------------------------------------------------
// irq_encoder_8to3
//
// Registered 8-to-3 priority encoder with per-source pending latches and a
// valid/ready grant handshake toward the core's exception/cause logic.
//
// Each request line sets a pending bit:
//   - edge sources (EDGE_MASK[i]=1) on a rising edge of req_i[i]
//   - level sources (EDGE_MASK[i]=0) whenever req_i[i] is high
// Pending bits are set regardless of mask_i. mask_i only decides which
// pending bits may be granted. A grant is presented as out_idx_o with
// out_valid_o. The index stays frozen until the consumer accepts it.
// On accept, the granted pending bit is cleared.
//
// Parameters:
//   EDGE_MASK   per-source trigger mode, 1 = rising edge, 0 = level
//   HIGH_FIRST  1 = index 7 has highest priority, 0 = index 0 has highest
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_i[7:0]   request lines, synchronous to clk
//   mask_i[7:0]  per-source enable for selection, 1 = enabled
//   out_valid_o  out_idx_o holds a grant
//   out_idx_o    encoded source index (bit i <-> code i)
//   out_ready_i  consumer accepts when out_valid_o & out_ready_i
//   pend_o[7:0]  raw pending register (unmasked), for status reads
//   any_pend_o   |(pend & mask_i), combinational from the pending register
//
// Optional feature, enabled by defining IRQ_ENC_OVF_EN:
//   ovf_clr_i    clears all sticky overflow flags (a simultaneous set wins)
//   ovf_o[7:0]   sticky flag: an edge arrived for an edge source whose pending
//                bit was already set and was not being cleared that cycle
// When the macro is undefined, those ports are absent. Edges that arrive
// while the source is already pending are merged into the pending bit.
// -----------------------------------------------------------------------------
module irq_encoder_8to3 #(
    parameter logic [7:0] EDGE_MASK  = 8'h00,
    parameter bit         HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    input  logic [7:0] mask_i,
    output logic       out_valid_o,
    output logic [2:0] out_idx_o,
    input  logic       out_ready_i,
    output logic [7:0] pend_o,
    output logic       any_pend_o
`ifdef IRQ_ENC_OVF_EN
    ,
    input  logic       ovf_clr_i,
    output logic [7:0] ovf_o
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Fixed-priority encoder over the candidate vector. With HIGH_FIRST the
    // upward scan lets the highest set bit overwrite lower ones. Without it,
    // the downward scan lets the lowest set bit win.
    function automatic logic [2:0] prio_enc(input logic [7:0] cand, input bit high_first);
        logic [2:0] idx;
        idx = 3'd0;
        if (high_first) begin
            for (int i = 0; i < 8; i++) begin
                idx = cand[i] ? i[2:0] : idx;
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                idx = cand[i] ? i[2:0] : idx;
            end
        end
        return idx;
    endfunction

    // 3-bit index to one-hot select. This is the inverse of prio_enc for a
    // single-bit input.
    function automatic logic [7:0] idx_dec(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    state_t     state_r;
    logic [7:0] req_q_r;
    logic [7:0] pend_r;
    logic       out_valid_r;
    logic [2:0] out_idx_r;

    logic [7:0] edge_s;
    logic [7:0] set_s;
    logic [7:0] clr_s;
    logic [7:0] cand_s;
    logic [7:0] pend_nxt_s;
    logic       accept_s;

    // The edge detector compares against the previous sample. Because req_q_r
    // resets to 0, a line that is already high on the first cycle after reset
    // counts as an edge.
    assign edge_s   = req_i & ~req_q_r;
    assign set_s    = (edge_s & EDGE_MASK) | (req_i & ~EDGE_MASK);
    assign accept_s = out_valid_r & out_ready_i;
    assign cand_s   = pend_r & mask_i;

    // Clear mask for the granted source on accept. A set in the same cycle
    // overrides this clear, so a level source that is still active re-pends
    // immediately.
    always_comb begin
        clr_s = 8'h00;
        if (accept_s) begin
            clr_s = idx_dec(out_idx_r);
        end else begin
            clr_s = 8'h00;
        end
        pend_nxt_s = (pend_r & ~clr_s) | set_s;
    end

    // Request sampling and pending latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q_r <= 8'h00;
            pend_r  <= 8'h00;
        end else begin
            req_q_r <= req_i;
            pend_r  <= pend_nxt_s;
        end
    end

    // Grant FSM. The index is captured only on IDLE->PRESENT. The index then
    // stays frozen until accept, even if the source is masked or its request
    // drops. The mandatory IDLE cycle after accept gives a settled pending
    // vector for the next selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_idx_r   <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|cand_s) begin
                        state_r     <= ST_PRESENT;
                        out_valid_r <= 1'b1;
                        out_idx_r   <= prio_enc(cand_s, HIGH_FIRST);
                    end else begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready_i) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_PRESENT;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_r;
    assign out_idx_o   = out_idx_r;
    assign pend_o      = pend_r;
    assign any_pend_o  = |cand_s;

`ifdef IRQ_ENC_OVF_EN
    logic [7:0] ovf_r;
    logic [7:0] ovf_set_s;
    logic [7:0] ovf_nxt_s;

    // An edge is lost only when it lands on a bit that is still pending after
    // this cycle. An edge on a bit that is being accepted in the same cycle
    // simply re-pends that bit.
    assign ovf_set_s = edge_s & EDGE_MASK & pend_r & ~clr_s;

    // Sticky overflow flags. On a clear, only the flags raised this cycle
    // survive, so a new overflow is never lost behind a clear.
    always_comb begin
        ovf_nxt_s = 8'h00;
        if (ovf_clr_i) begin
            ovf_nxt_s = ovf_set_s;
        end else begin
            ovf_nxt_s = ovf_r | ovf_set_s;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 8'h00;
        end else begin
            ovf_r <= ovf_nxt_s;
        end
    end

    assign ovf_o = ovf_r;
`endif

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// -----------------------------------------------------------------------------
// tb_irq_encoder_8to3
//
// Directed self-checking bench for irq_encoder_8to3. It uses three instances:
//   u_lvl : all level sources, index 7 highest priority
//   u_edg : all edge sources,  index 7 highest priority
//   u_low : all level sources, index 0 highest priority
// Inputs are driven 1 ns after the rising edge. Outputs are sampled at the
// same point, so they reflect the state registered on that edge.
// -----------------------------------------------------------------------------
module tb_irq_encoder_8to3;

    logic       clk;
    logic       rst_n;

    logic [7:0] lv_req, lv_mask, lv_pend;
    logic       lv_ready, lv_valid, lv_any;
    logic [2:0] lv_idx;

    logic [7:0] ed_req, ed_mask, ed_pend;
    logic       ed_ready, ed_valid, ed_any;
    logic [2:0] ed_idx;

    logic [7:0] lo_req, lo_mask, lo_pend;
    logic       lo_ready, lo_valid, lo_any;
    logic [2:0] lo_idx;

`ifdef IRQ_ENC_OVF_EN
    logic       ed_ovf_clr, lv_ovf_clr, lo_ovf_clr;
    logic [7:0] ed_ovf, lv_ovf, lo_ovf;
`endif

    int n_cmp;
    int n_bad;

    irq_encoder_8to3 #(.EDGE_MASK(8'h00), .HIGH_FIRST(1'b1)) u_lvl (
        .clk(clk), .rst_n(rst_n), .req_i(lv_req), .mask_i(lv_mask),
        .out_valid_o(lv_valid), .out_idx_o(lv_idx), .out_ready_i(lv_ready),
        .pend_o(lv_pend), .any_pend_o(lv_any)
`ifdef IRQ_ENC_OVF_EN
        , .ovf_clr_i(lv_ovf_clr), .ovf_o(lv_ovf)
`endif
    );

    irq_encoder_8to3 #(.EDGE_MASK(8'hFF), .HIGH_FIRST(1'b1)) u_edg (
        .clk(clk), .rst_n(rst_n), .req_i(ed_req), .mask_i(ed_mask),
        .out_valid_o(ed_valid), .out_idx_o(ed_idx), .out_ready_i(ed_ready),
        .pend_o(ed_pend), .any_pend_o(ed_any)
`ifdef IRQ_ENC_OVF_EN
        , .ovf_clr_i(ed_ovf_clr), .ovf_o(ed_ovf)
`endif
    );

    irq_encoder_8to3 #(.EDGE_MASK(8'h00), .HIGH_FIRST(1'b0)) u_low (
        .clk(clk), .rst_n(rst_n), .req_i(lo_req), .mask_i(lo_mask),
        .out_valid_o(lo_valid), .out_idx_o(lo_idx), .out_ready_i(lo_ready),
        .pend_o(lo_pend), .any_pend_o(lo_any)
`ifdef IRQ_ENC_OVF_EN
        , .ovf_clr_i(lo_ovf_clr), .ovf_o(lo_ovf)
`endif
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_lvl();
        lv_req   = 8'h00;
        lv_mask  = 8'hFF;
        lv_ready = 1'b1;
        repeat (20) tick();
        n_cmp++; if ({lv_valid, lv_pend} !== {1'b0, 8'h00}) begin n_bad++; $display("FAIL drain_lvl: got %h want %h", {lv_valid, lv_pend}, {1'b0, 8'h00}); end
        lv_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        lv_req   = 8'h00; lv_mask = 8'hFF; lv_ready = 1'b0;
        ed_req   = 8'h00; ed_mask = 8'hFF; ed_ready = 1'b0;
        lo_req   = 8'h00; lo_mask = 8'hFF; lo_ready = 1'b0;
`ifdef IRQ_ENC_OVF_EN
        ed_ovf_clr = 1'b0; lv_ovf_clr = 1'b0; lo_ovf_clr = 1'b0;
`endif
        repeat (3) tick();
        n_cmp++; if ({lv_valid, lv_idx, lv_pend} !== 12'h000) begin n_bad++; $display("FAIL reset_held: got %h want %h", {lv_valid, lv_idx, lv_pend}, 12'h000); end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++; if ({lv_valid, lv_idx, lv_pend, lv_any} !== 13'h0000) begin n_bad++; $display("FAIL reset_idle_lvl c%0d: got %h want %h", c, {lv_valid, lv_idx, lv_pend, lv_any}, 13'h0000); end
            n_cmp++; if ({ed_valid, ed_idx, ed_pend, ed_any} !== 13'h0000) begin n_bad++; $display("FAIL reset_idle_edg c%0d: got %h want %h", c, {ed_valid, ed_idx, ed_pend, ed_any}, 13'h0000); end
        end
    endtask

    task automatic test_priority();
        lv_req = 8'h24; lv_ready = 1'b1;
        tick();
        n_cmp++; if ({lv_valid, lv_pend, lv_any} !== {1'b0, 8'h24, 1'b1}) begin n_bad++; $display("FAIL prio_pend: got %h want %h", {lv_valid, lv_pend, lv_any}, {1'b0, 8'h24, 1'b1}); end
        tick();
        n_cmp++; if ({lv_valid, lv_idx} !== {1'b1, 3'd5}) begin n_bad++; $display("FAIL prio_grant1: got %h want %h", {lv_valid, lv_idx}, {1'b1, 3'd5}); end
        tick();
        n_cmp++; if ({lv_valid, lv_pend} !== {1'b0, 8'h24}) begin n_bad++; $display("FAIL prio_bubble_repend: got %h want %h", {lv_valid, lv_pend}, {1'b0, 8'h24}); end
        tick();
        n_cmp++; if ({lv_valid, lv_idx} !== {1'b1, 3'd5}) begin n_bad++; $display("FAIL prio_grant2: got %h want %h", {lv_valid, lv_idx}, {1'b1, 3'd5}); end
        tick(); tick();
        n_cmp++; if ({lv_valid, lv_idx} !== {1'b1, 3'd5}) begin n_bad++; $display("FAIL prio_grant3: got %h want %h", {lv_valid, lv_idx}, {1'b1, 3'd5}); end
        lv_req = 8'h04;
        tick();
        n_cmp++; if ({lv_valid, lv_pend} !== {1'b0, 8'h04}) begin n_bad++; $display("FAIL prio_drop5: got %h want %h", {lv_valid, lv_pend}, {1'b0, 8'h04}); end
        tick();
        n_cmp++; if ({lv_valid, lv_idx} !== {1'b1, 3'd2}) begin n_bad++; $display("FAIL prio_grant_idx2: got %h want %h", {lv_valid, lv_idx}, {1'b1, 3'd2}); end
        drain_lvl();
    endtask

    task automatic test_backpressure();
        lv_req = 8'h08; lv_ready = 1'b0;
        tick(); tick();
        n_cmp++; if ({lv_valid, lv_idx} !== {1'b1, 3'd3}) begin n_bad++; $display("FAIL bp_grant3: got %h want %h", {lv_valid, lv_idx}, {1'b1, 3'd3}); end
        lv_req = 8'h80;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if ({lv_valid, lv_idx} !== {1'b1, 3'd3}) begin n_bad++; $display("FAIL bp_hold c%0d: got %h want %h", c, {lv_valid, lv_idx}, {1'b1, 3'd3}); end
        end
        n_cmp++; if (lv_pend !== 8'h88) begin n_bad++; $display("FAIL bp_pend: got %h want %h", lv_pend, 8'h88); end
        lv_ready = 1'b1;
        tick();
        n_cmp++; if ({lv_valid, lv_pend} !== {1'b0, 8'h80}) begin n_bad++; $display("FAIL bp_bubble: got %h want %h", {lv_valid, lv_pend}, {1'b0, 8'h80}); end
        tick();
        n_cmp++; if ({lv_valid, lv_idx} !== {1'b1, 3'd7}) begin n_bad++; $display("FAIL bp_grant7: got %h want %h", {lv_valid, lv_idx}, {1'b1, 3'd7}); end
        drain_lvl();
    endtask

    task automatic test_mask();
        lv_req = 8'h81; lv_mask = 8'h01; lv_ready = 1'b0;
        tick();
        n_cmp++; if ({lv_valid, lv_pend, lv_any} !== {1'b0, 8'h81, 1'b1}) begin n_bad++; $display("FAIL mask_pend: got %h want %h", {lv_valid, lv_pend, lv_any}, {1'b0, 8'h81, 1'b1}); end
        tick();
        n_cmp++; if ({lv_valid, lv_idx, lv_pend} !== {1'b1, 3'd0, 8'h81}) begin n_bad++; $display("FAIL mask_grant0: got %h want %h", {lv_valid, lv_idx, lv_pend}, {1'b1, 3'd0, 8'h81}); end
        lv_mask = 8'h00;
        tick();
        n_cmp++; if ({lv_valid, lv_idx, lv_any} !== {1'b1, 3'd0, 1'b0}) begin n_bad++; $display("FAIL mask_hold_masked: got %h want %h", {lv_valid, lv_idx, lv_any}, {1'b1, 3'd0, 1'b0}); end
        lv_mask = 8'hFF; lv_ready = 1'b1;
        tick();
        n_cmp++; if ({lv_valid, lv_pend} !== {1'b0, 8'h81}) begin n_bad++; $display("FAIL mask_accept0: got %h want %h", {lv_valid, lv_pend}, {1'b0, 8'h81}); end
        tick();
        n_cmp++; if ({lv_valid, lv_idx} !== {1'b1, 3'd7}) begin n_bad++; $display("FAIL mask_grant7: got %h want %h", {lv_valid, lv_idx}, {1'b1, 3'd7}); end
        drain_lvl();
    endtask

    task automatic test_low_first();
        lo_req = 8'h24; lo_ready = 1'b1;
        tick(); tick();
        n_cmp++; if ({lo_valid, lo_idx} !== {1'b1, 3'd2}) begin n_bad++; $display("FAIL low_grant2: got %h want %h", {lo_valid, lo_idx}, {1'b1, 3'd2}); end
        lo_req = 8'h20;
        tick();
        n_cmp++; if ({lo_valid, lo_pend} !== {1'b0, 8'h20}) begin n_bad++; $display("FAIL low_pend20: got %h want %h", {lo_valid, lo_pend}, {1'b0, 8'h20}); end
        tick();
        n_cmp++; if ({lo_valid, lo_idx} !== {1'b1, 3'd5}) begin n_bad++; $display("FAIL low_grant5: got %h want %h", {lo_valid, lo_idx}, {1'b1, 3'd5}); end
        lo_req = 8'h00;
        repeat (6) tick();
        n_cmp++; if ({lo_valid, lo_pend} !== {1'b0, 8'h00}) begin n_bad++; $display("FAIL low_drain: got %h want %h", {lo_valid, lo_pend}, {1'b0, 8'h00}); end
    endtask

    task automatic test_async_reset();
        lv_req = 8'h10; lv_ready = 1'b0;
        tick(); tick();
        n_cmp++; if ({lv_valid, lv_idx} !== {1'b1, 3'd4}) begin n_bad++; $display("FAIL arst_pre_grant: got %h want %h", {lv_valid, lv_idx}, {1'b1, 3'd4}); end
        // ed_req is held high across reset release, so the first sampled
        // cycle must count as an edge.
        ed_req = 8'h40; ed_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({lv_valid, lv_idx, lv_pend} !== 12'h000) begin n_bad++; $display("FAIL arst_immediate: got %h want %h", {lv_valid, lv_idx, lv_pend}, 12'h000); end
        lv_req = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if ({ed_valid, ed_pend} !== {1'b0, 8'h40}) begin n_bad++; $display("FAIL arst_first_edge: got %h want %h", {ed_valid, ed_pend}, {1'b0, 8'h40}); end
        tick();
        n_cmp++; if ({ed_valid, ed_idx} !== {1'b1, 3'd6}) begin n_bad++; $display("FAIL arst_grant6: got %h want %h", {ed_valid, ed_idx}, {1'b1, 3'd6}); end
        ed_ready = 1'b1;
        tick();
        n_cmp++; if ({ed_valid, ed_pend} !== {1'b0, 8'h00}) begin n_bad++; $display("FAIL arst_accept6: got %h want %h", {ed_valid, ed_pend}, {1'b0, 8'h00}); end
        tick();
        n_cmp++; if (ed_valid !== 1'b0) begin n_bad++; $display("FAIL arst_no_regrant: got %b want %b", ed_valid, 1'b0); end
        ed_req = 8'h00;
        tick();
    endtask

    task automatic test_edge();
        int grants;
        ed_ready = 1'b1;
        ed_req = 8'h02;
        tick();
        n_cmp++; if ({ed_valid, ed_pend} !== {1'b0, 8'h02}) begin n_bad++; $display("FAIL edge_pend: got %h want %h", {ed_valid, ed_pend}, {1'b0, 8'h02}); end
        ed_req = 8'h00;
        tick();
        n_cmp++; if ({ed_valid, ed_idx, ed_pend} !== {1'b1, 3'd1, 8'h02}) begin n_bad++; $display("FAIL edge_grant1: got %h want %h", {ed_valid, ed_idx, ed_pend}, {1'b1, 3'd1, 8'h02}); end
        tick();
        n_cmp++; if ({ed_valid, ed_pend} !== {1'b0, 8'h00}) begin n_bad++; $display("FAIL edge_cleared: got %h want %h", {ed_valid, ed_pend}, {1'b0, 8'h00}); end
        tick(); tick();
        n_cmp++; if (ed_valid !== 1'b0) begin n_bad++; $display("FAIL edge_no_regrant: got %b want %b", ed_valid, 1'b0); end
        ed_req = 8'h02;
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ed_valid === 1'b1) grants++;
        end
        n_cmp++; if (grants !== 1) begin n_bad++; $display("FAIL edge_held_once: got %0d want %0d", grants, 1); end
        n_cmp++; if (ed_pend !== 8'h00) begin n_bad++; $display("FAIL edge_held_pend: got %h want %h", ed_pend, 8'h00); end
        ed_req = 8'h00;
        tick();
    endtask

`ifdef IRQ_ENC_OVF_EN
    task automatic test_ovf();
        ed_ready = 1'b0;
        ed_req = 8'h10;
        tick();
        n_cmp++; if ({ed_pend, ed_ovf} !== {8'h10, 8'h00}) begin n_bad++; $display("FAIL ovf_first_pulse: got %h want %h", {ed_pend, ed_ovf}, {8'h10, 8'h00}); end
        ed_req = 8'h00;
        tick();
        n_cmp++; if ({ed_valid, ed_idx} !== {1'b1, 3'd4}) begin n_bad++; $display("FAIL ovf_grant4: got %h want %h", {ed_valid, ed_idx}, {1'b1, 3'd4}); end
        ed_req = 8'h10;
        tick();
        n_cmp++; if (ed_ovf !== 8'h10) begin n_bad++; $display("FAIL ovf_set: got %h want %h", ed_ovf, 8'h10); end
        ed_req = 8'h00; ed_ovf_clr = 1'b1;
        tick();
        n_cmp++; if (ed_ovf !== 8'h00) begin n_bad++; $display("FAIL ovf_clear: got %h want %h", ed_ovf, 8'h00); end
        ed_req = 8'h10;
        tick();
        n_cmp++; if (ed_ovf !== 8'h10) begin n_bad++; $display("FAIL ovf_set_wins: got %h want %h", ed_ovf, 8'h10); end
        ed_req = 8'h00;
        tick();
        n_cmp++; if (ed_ovf !== 8'h00) begin n_bad++; $display("FAIL ovf_clear2: got %h want %h", ed_ovf, 8'h00); end
        ed_ovf_clr = 1'b0; ed_ready = 1'b1;
        repeat (6) tick();
        n_cmp++; if ({ed_valid, ed_pend} !== {1'b0, 8'h00}) begin n_bad++; $display("FAIL ovf_drain: got %h want %h", {ed_valid, ed_pend}, {1'b0, 8'h00}); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_priority();
        test_backpressure();
        test_mask();
        test_low_first();
        test_async_reset();
        test_edge();
`ifdef IRQ_ENC_OVF_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_encoder_8to3.md
Name: irq_encoder_8to3

Overview:
Registered 8-to-3 priority encoder with pending latches and a valid/ready output handshake. It collects eight interrupt/event request lines, masks them, and presents the index of the highest-priority pending source to the CPU-side consumer. The index is bit i ↔ code i, which is the inverse of the 3-bit to one-hot select decode used elsewhere in the datapath. It sits between peripheral event lines and the core's exception/cause logic.

Parameters:
EDGE_MASK, 8'h00, per-source mode: bit i = 1 makes source i rising-edge triggered; 0 makes it level triggered.
HIGH_FIRST, 1, 1 = index 7 has highest priority; 0 = index 0 has highest priority.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_i  in  8  request lines, synchronous to clk
mask_i  in  8  enable per source, 1 = enabled
out_valid_o  out  1  out_idx_o holds a grant
out_idx_o  out  3  encoded source index
out_ready_i  in  1  consumer accepts when out_valid_o & out_ready_i
pend_o  out  8  raw pending register (unmasked), for status reads
any_pend_o  out  1  |(pend & mask_i), combinational from registers

Behaviour:
- Reset (async, rst_n=0): pend=0, req_q=0, state=IDLE, out_valid_o=0, out_idx_o=0. All state is cleared immediately, including mid-handshake.
- Edge detect: req_q <= req_i every cycle. Edge event for source i is req_i[i] & ~req_q[i]. If req_i[i] is high on the first cycle after reset, this counts as an edge.
- Pending set condition:
  - Edge source: edge event.
  - Level source: req_i[i]==1.
  - Set happens regardless of mask_i; masking only gates selection.
- Pending clear: pend[out_idx_o] clears on accept. If a set condition for the same bit occurs in the same cycle, set wins and the bit stays 1.
- FSM has 2 states:
  - IDLE: out_valid_o=0. If |(pend & mask_i), capture the priority-encoded index into out_idx_o and go to PRESENT.
  - PRESENT: out_valid_o=1. out_idx_o is held stable until accept, even if that source becomes masked or its req drops. On accept, go to IDLE.
- Latency:
  - req_i high sampled at edge k → pend at k → out_valid_o after edge k+1.
  - After accept at edge m, out_valid_o=0 for one cycle. The next grant is valid after edge m+1, so maximum throughput is one grant per 2 cycles.
- Priority: fixed, per HIGH_FIRST, among pend & mask_i bits only. With no candidates, stay in IDLE.
- Level source still high after accept: it re-pends in the same cycle (set wins) and is granted again.
- out_ready_i while out_valid_o=0 has no effect.
- X-free: out_idx_o changes only on an IDLE→PRESENT transition.

Optional Feature:
IRQ_ENC_OVF_EN
- Defined:
  - Adds input ovf_clr_i (1) and output ovf_o (8).
  - ovf_o[i] sets sticky when an edge event arrives for an edge source i whose pend[i] is already 1 and is not being cleared in that cycle.
  - ovf_clr_i=1 clears all ovf_o bits; a simultaneous overflow set wins.
  - Reset value is 0.
- Undefined: the ports are absent and lost edges are silently merged.

Test Plan:
- Reset/idle: rst_n=0 then 1 with req_i=0, mask_i=FF → out_valid_o=0, out_idx_o=0, pend_o=00 for 10 cycles. Asserting rst_n=0 during PRESENT drops out_valid_o immediately.
- Priority (HIGH_FIRST=1, level, mask=FF): req_i=8'b0010_0100 held, out_ready_i=1 → grants idx 5, 5, 5… (level re-pends). Drop req[5] → grants idx 2.
- Backpressure: grant idx 3 with out_ready_i=0 for 5 cycles while req_i changes to 8'h80 → out_idx_o stays 3 and out_valid_o stays 1. Raise ready → accept, one bubble cycle, then grant 7.
- Edge mode (EDGE_MASK=FF): pulse req_i[1] for 1 cycle → pend_o=02 one cycle later, out_valid_o the cycle after, idx 1. After accept → pend_o=00 and no further grant. Holding req_i[1] high gives exactly one grant.
- Masking: req_i=8'h81 level, mask_i=8'h01 → only idx 0 granted, pend_o=81. Set mask_i=FF → idx 7 granted next.
- With IRQ_ENC_OVF_EN (EDGE_MASK=FF, out_ready_i=0): two pulses on req_i[4] before accept → ovf_o=8'h10. Pulse ovf_clr_i → ovf_o=00.
